rom_rr_arbiter: RTL and testbench
=================================

Name: rom_rr_arbiter

Overview:
Round-robin arbiter that shares one read-only memory between NUM_REQ requesters.
- Accepts per-requester valid/ready read requests and drives a single registered ROM address.
- Waits a fixed ROM latency, captures the data, and returns it on a tagged response channel with backpressure.
- Sits between client blocks and the rom_simple instance. The ROM itself is combinational (ROM_LATENCY=0) or pipelined.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, ROM word width
ADDR_WIDTH, 8, ROM address width
ROM_LATENCY, 1, cycles from rom_addr change to valid rom_data (0..3)
DEPTH, 256, number of populated ROM words; used only by the optional feature

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester read request
req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i
req_ready  output  NUM_REQ  one-hot accept pulse
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  clog2(NUM_REQ)  index of the requester that owns the response
rsp_data  output  DATA_WIDTH  ROM word read
rom_addr  output  ADDR_WIDTH  registered address to ROM
rom_data  input  DATA_WIDTH  ROM read data
busy  output  1  high whenever state is not IDLE

Behaviour:
- One clock; reset is asynchronous and active-low.
- While rst_n=0, all outputs are held low:
  - state=IDLE, rr pointer=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rom_addr=0, busy=0.
- FSM states: IDLE, WAIT, RESP.
- Accept window is (IDLE) or (RESP and rsp_ready=1).
  - In the accept window, with any req_valid high: grant the first valid requester searching from pointer upward, wrapping modulo NUM_REQ.
  - req_ready[g]=1 in the same cycle; the grant is combinational from req_valid.
  - On that edge: rom_addr<=slice g, rsp_id<=g, pointer<=(g+1) mod NUM_REQ, lat_cnt<=ROM_LATENCY, state<=WAIT.
- No valid request in the accept window: IDLE stays IDLE; RESP with rsp_ready goes to IDLE. req_ready stays 0 outside the accept window.
- WAIT: each edge, if lat_cnt==0, capture rsp_data<=rom_data and go to RESP; otherwise decrement lat_cnt.
  - Accept-edge to rsp_valid rise is exactly ROM_LATENCY+1 cycles.
- RESP: rsp_valid=1. rsp_id and rsp_data are held stable until the rsp_valid&rsp_ready edge.
  - A back-to-back accept in the same cycle is allowed, so there is no idle bubble.
  - Peak throughput is one read per ROM_LATENCY+2 cycles.
- A requester dropping req_valid before grant simply loses eligibility. There is no error and the pointer does not move.
- Requesters must hold req_addr stable while req_valid=1. The arbiter samples the address only on the accept edge.
- Reset asserted in WAIT or RESP aborts the transaction immediately. No response is emitted after release.
- Pointer wraps from NUM_REQ-1 to 0. rsp_id width is max(1, clog2(NUM_REQ)).

Optional Feature:
Macro ROM_ARB_RANGE_CHK_EN.
- Defined:
  - Adds output port rsp_err (1 bit, reset 0, valid with rsp_valid).
  - Granted address >= DEPTH: rsp_err=1 and rsp_data=0, regardless of rom_data. Timing is unchanged.
  - Address < DEPTH: rsp_err=0.
- Undefined: no rsp_err port, no comparator, and DEPTH is ignored.

Decomposition:
- Package rom_arb_pkg:
  - FSM state encoding constants (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - Latency counter width constant (2 bits).
  - Function computing the id width from NUM_REQ.
- One sub-module, rr_grant:
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational.

Test Plan:
1. NUM_REQ=4, ROM_LATENCY=1, mem[0x3C]=0xA5; req_valid[2]=1 with addr 0x3C in IDLE -> req_ready=4'b0100 for one cycle; rom_addr=0x3C; rsp_valid rises 2 cycles after accept edge with rsp_id=2, rsp_data=0xA5.
2. All req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0,1; each requester receives 2 of the first 8 grants; no idle cycle between responses.
3. rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_id, rsp_data stable; req_ready=0 throughout; after rsp_ready=1, a pending req_valid[1] is accepted in the same cycle.
4. ROM_LATENCY=0 and ROM_LATENCY=3 builds -> rsp_valid rises exactly 1 and 4 cycles after accept; rsp_data matches mem[addr].
5. rst_n pulled low mid-WAIT, asynchronously -> all outputs 0 before the next clk edge; after release, no response for the aborted read and the pointer is back at requester 0.
6. ROM_ARB_RANGE_CHK_EN, DEPTH=200: addr 0xD0 -> rsp_err=1, rsp_data=0; addr 0x10 -> rsp_err=0, rsp_data=mem[0x10].

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared definitions for the round-robin ROM arbiter: FSM state encoding,
// latency counter width and the requester-id width helper.
package rom_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Wide enough to hold the largest supported ROM latency (3).
  localparam int LAT_CNT_W = 2;

  // Requester id width; never narrower than one bit, even for a single requester.
  function automatic int id_width(input int num_req);
    return (num_req < 2) ? 1 : $clog2(num_req);
  endfunction

endpackage : rom_arb_pkg

// File: rtl/rr_grant.sv
// Combinational round-robin grant: picks the first asserted request at or
// above the pointer, wrapping modulo NUM_REQ.
module rr_grant
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_grant
);

  // Rotating priority search starting at the pointer.
  always_comb begin
    int idx;
    // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant_idx  = ID_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

endmodule : rr_grant

// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter sharing one ROM between NUM_REQ requesters.
// Each accepted request drives a registered ROM address, waits ROM_LATENCY
// cycles, captures the word and returns it on a tagged response channel.
// Optional macro ROM_ARB_RANGE_CHK_EN adds rsp_err, flagging addresses >= DEPTH.
module rom_rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_WIDTH  = 8,
  parameter  int ADDR_WIDTH  = 8,
  parameter  int ROM_LATENCY = 1,
  parameter  int DEPTH       = 256,
  localparam int ID_W        = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0]         rom_data,
`ifdef ROM_ARB_RANGE_CHK_EN
  output logic                          rsp_err,
`endif
  output logic                          busy
);

  arb_state_t             state;
  arb_state_t             state_next;
  logic [ID_W-1:0]        ptr;
  logic [LAT_CNT_W-1:0]   lat_cnt;
  logic                   accept;
  logic                   capture;
  logic [NUM_REQ-1:0]     grant;
  logic [ID_W-1:0]        grant_idx;
  logic                   any_grant;
  logic [ADDR_WIDTH-1:0]  grant_addr;
  logic [ID_W-1:0]        ptr_next;
`ifdef ROM_ARB_RANGE_CHK_EN
  logic                   addr_err;
`endif

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_grant (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Address of the winning requester and the pointer position just past it.
  always_comb begin
    grant_addr = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    ptr_next   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Next-state and handshake decode; accepts only in IDLE or on a consumed response.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (any_grant) begin
          accept     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == '0) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          if (any_grant) begin
            accept     = 1'b1;
            state_next = WAIT;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // The grant is combinational from req_valid, so gate it with reset to keep
    // req_ready low while the arbiter is held in reset.
    req_ready = (accept && rst_n) ? grant : '0;
    rsp_valid = (state == RESP);
    busy      = (state != IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
    end
  end

  // Datapath: latch request on accept, count down ROM latency, capture response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: a handful of control/data registers, not a memory array, so all are cleared on reset.
      ptr      <= '0;
      lat_cnt  <= '0;
      rom_addr <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
`ifdef ROM_ARB_RANGE_CHK_EN
      addr_err <= 1'b0;
      rsp_err  <= 1'b0;
`endif
    end else if (accept) begin
      rom_addr <= grant_addr;
      rsp_id   <= grant_idx;
      ptr      <= ptr_next;
      lat_cnt  <= LAT_CNT_W'(ROM_LATENCY);
`ifdef ROM_ARB_RANGE_CHK_EN
      addr_err <= (32'(grant_addr) >= 32'(DEPTH));
`endif
    end else if (state == WAIT) begin
      if (capture) begin
`ifdef ROM_ARB_RANGE_CHK_EN
        rsp_data <= addr_err ? '0 : rom_data;
        rsp_err  <= addr_err;
`else
        rsp_data <= rom_data;
`endif
      end else begin
        lat_cnt <= lat_cnt - 1'b1;
      end
    end
  end

endmodule : rom_rr_arbiter

// File: tb/tb_rom_rr_arbiter.sv
// Directed self-checking bench for rom_rr_arbiter. Three instances share the
// request stimulus: latency 1 (main), latency 0 and latency 3. Each has its own
// ROM model returning addr ^ 8'h99 after the configured latency.
// With ROM_ARB_RANGE_CHK_EN defined, the range-error path is also exercised.
module tb_rom_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_addr;
  logic        rsp_ready;

  logic [3:0] m_req_ready, z_req_ready, t_req_ready;
  logic       m_rsp_valid, z_rsp_valid, t_rsp_valid;
  logic [1:0] m_rsp_id,    z_rsp_id,    t_rsp_id;
  logic [7:0] m_rsp_data,  z_rsp_data,  t_rsp_data;
  logic [7:0] m_rom_addr,  z_rom_addr,  t_rom_addr;
  logic [7:0] m_rom_data,  z_rom_data,  t_rom_data;
  logic       m_busy,      z_busy,      t_busy;
  logic [7:0] t_p1, t_p2;
`ifdef ROM_ARB_RANGE_CHK_EN
  logic       m_rsp_err, z_rsp_err, t_rsp_err;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  function automatic logic [7:0] rom_word(input logic [7:0] a);
    return a ^ 8'h99;
  endfunction

  // ROM models: combinational, one-stage and three-stage pipelines.
  assign z_rom_data = rom_word(z_rom_addr);
  always @(posedge clk) begin
    m_rom_data <= rom_word(m_rom_addr);
    t_p1       <= rom_word(t_rom_addr);
    t_p2       <= t_p1;
    t_rom_data <= t_p2;
  end

  always #5 clk = ~clk;

  rom_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(8), .ROM_LATENCY(1), .DEPTH(200)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_ready(m_req_ready),
    .rsp_valid(m_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(m_rsp_id), .rsp_data(m_rsp_data),
    .rom_addr(m_rom_addr), .rom_data(m_rom_data),
`ifdef ROM_ARB_RANGE_CHK_EN
    .rsp_err(m_rsp_err),
`endif
    .busy(m_busy));

  rom_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(8), .ROM_LATENCY(0), .DEPTH(200)) u_dut_l0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_ready(z_req_ready),
    .rsp_valid(z_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(z_rsp_id), .rsp_data(z_rsp_data),
    .rom_addr(z_rom_addr), .rom_data(z_rom_data),
`ifdef ROM_ARB_RANGE_CHK_EN
    .rsp_err(z_rsp_err),
`endif
    .busy(z_busy));

  rom_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(8), .ROM_LATENCY(3), .DEPTH(200)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_ready(t_req_ready),
    .rsp_valid(t_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(t_rsp_id), .rsp_data(t_rsp_data),
    .rom_addr(t_rom_addr), .rom_data(t_rom_data),
`ifdef ROM_ARB_RANGE_CHK_EN
    .rsp_err(t_rsp_err),
`endif
    .busy(t_busy));

  // Advance to 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_addr(input int i, input logic [7:0] a);
    req_addr[i*8 +: 8] = a;
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_addr  = 32'h0403_0201;
    rsp_ready = 1'b1;
    #3;
    tests_run++;
    if (m_req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_req_ready: got %b want 0000", m_req_ready); end
    tests_run++;
    if (m_rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b want 0", m_rsp_valid); end
    tests_run++;
    if (m_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", m_busy); end
    tests_run++;
    if ({m_rsp_id, m_rsp_data, m_rom_addr} !== 18'd0) begin
      tests_failed++; $display("FAIL reset_regs: got id=%0d data=%h addr=%h want all 0", m_rsp_id, m_rsp_data, m_rom_addr);
    end
  endtask

  task automatic test_single();
    reset_dut();
    set_addr(2, 8'h3C);
    req_valid = 4'b0100;
    #1;
    tests_run++;
    if (m_req_ready !== 4'b0100) begin tests_failed++; $display("FAIL single_ready: got %b want 0100", m_req_ready); end
    tick();
    req_valid = '0;
    #1;
    tests_run++;
    if (m_rom_addr !== 8'h3C || m_busy !== 1'b1 || m_req_ready !== 4'b0000) begin
      tests_failed++; $display("FAIL single_accept: got addr=%h busy=%b ready=%b want 3c 1 0000", m_rom_addr, m_busy, m_req_ready);
    end
    tick();
    tests_run++;
    if (m_rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL single_early_rsp: got %b want 0 one cycle after accept", m_rsp_valid); end
    tick();
    tests_run++;
    if (m_rsp_valid !== 1'b1 || m_rsp_id !== 2'd2 || m_rsp_data !== 8'hA5) begin
      tests_failed++; $display("FAIL single_rsp: got v=%b id=%0d data=%h want 1 2 a5", m_rsp_valid, m_rsp_id, m_rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    tests_run++;
    if (m_rsp_valid !== 1'b0 || m_busy !== 1'b0) begin
      tests_failed++; $display("FAIL single_idle: got v=%b busy=%b want 0 0", m_rsp_valid, m_busy);
    end
  endtask

  task automatic test_round_robin();
    int g_cnt    = 0;
    int last_cyc = -1;
    int r_cnt    = 0;
    logic [3:0] exp_g;
    reset_dut();
    for (int i = 0; i < 4; i++) set_addr(i, 8'h10 + 8'(i));
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 40 && g_cnt < 8; cyc++) begin
      if (m_rsp_valid) begin
        tests_run++;
        if (m_rsp_id !== 2'(r_cnt % 4) || m_rsp_data !== rom_word(8'h10 + 8'(r_cnt % 4))) begin
          tests_failed++;
          $display("FAIL rr_rsp%0d: got id=%0d data=%h want %0d %h", r_cnt, m_rsp_id, m_rsp_data, r_cnt % 4, rom_word(8'h10 + 8'(r_cnt % 4)));
        end
        r_cnt++;
      end
      if (m_req_ready !== 4'b0000) begin
        exp_g = 4'b0001 << (g_cnt % 4);
        tests_run++;
        if (m_req_ready !== exp_g) begin tests_failed++; $display("FAIL rr_grant%0d: got %b want %b", g_cnt, m_req_ready, exp_g); end
        if (last_cyc >= 0) begin
          tests_run++;
          if (cyc - last_cyc != 3) begin tests_failed++; $display("FAIL rr_gap%0d: got %0d cycles want 3", g_cnt, cyc - last_cyc); end
        end
        last_cyc = cyc;
        g_cnt++;
      end
      tick();
    end
    tests_run++;
    if (g_cnt != 8) begin tests_failed++; $display("FAIL rr_grant_count: got %0d want 8", g_cnt); end
    req_valid = '0;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_backpressure();
    reset_dut();
    set_addr(0, 8'h20);
    req_valid = 4'b0001;
    #1;
    tests_run++;
    if (m_req_ready !== 4'b0001) begin tests_failed++; $display("FAIL bp_first_ready: got %b want 0001", m_req_ready); end
    tick();
    set_addr(1, 8'h21);
    req_valid = 4'b0010;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (m_rsp_valid) break;
      tests_run++;
      if (m_req_ready !== 4'b0000) begin tests_failed++; $display("FAIL bp_wait_ready: got %b want 0000", m_req_ready); end
      tick();
    end
    tests_run++;
    if (m_rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_rsp_timeout: got rsp_valid=%b want 1", m_rsp_valid); end
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if ({m_rsp_valid, m_rsp_id, m_rsp_data, m_req_ready} !== {1'b1, 2'd0, rom_word(8'h20), 4'b0000}) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: got v=%b id=%0d data=%h ready=%b want 1 0 %h 0000", k, m_rsp_valid, m_rsp_id, m_rsp_data, m_req_ready, rom_word(8'h20));
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    tests_run++;
    if (m_req_ready !== 4'b0010) begin tests_failed++; $display("FAIL bp_b2b_ready: got %b want 0010", m_req_ready); end
    tick();
    req_valid = '0;
    #1;
    tests_run++;
    if (m_rom_addr !== 8'h21 || m_rsp_valid !== 1'b0 || m_busy !== 1'b1) begin
      tests_failed++; $display("FAIL bp_b2b_accept: got addr=%h v=%b busy=%b want 21 0 1", m_rom_addr, m_rsp_valid, m_busy);
    end
    for (int c = 0; c < 10; c++) begin
      if (m_rsp_valid) break;
      tick();
    end
    tests_run++;
    if (m_rsp_valid !== 1'b1 || m_rsp_id !== 2'd1 || m_rsp_data !== rom_word(8'h21)) begin
      tests_failed++; $display("FAIL bp_second_rsp: got v=%b id=%0d data=%h want 1 1 %h", m_rsp_valid, m_rsp_id, m_rsp_data, rom_word(8'h21));
    end
    tick();
  endtask

  task automatic test_latency();
    int lat_m = -1;
    int lat_z = -1;
    int lat_t = -1;
    reset_dut();
    set_addr(3, 8'h42);
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    #1;
    tick();
    req_valid = '0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (z_rsp_valid && lat_z < 0) begin
        lat_z = n;
        tests_run++;
        if (z_rsp_data !== rom_word(8'h42) || z_rsp_id !== 2'd3) begin
          tests_failed++; $display("FAIL lat0_data: got id=%0d data=%h want 3 %h", z_rsp_id, z_rsp_data, rom_word(8'h42));
        end
      end
      if (m_rsp_valid && lat_m < 0) lat_m = n;
      if (t_rsp_valid && lat_t < 0) begin
        lat_t = n;
        tests_run++;
        if (t_rsp_data !== rom_word(8'h42) || t_rsp_id !== 2'd3) begin
          tests_failed++; $display("FAIL lat3_data: got id=%0d data=%h want 3 %h", t_rsp_id, t_rsp_data, rom_word(8'h42));
        end
      end
    end
    tests_run++;
    if (lat_z != 1) begin tests_failed++; $display("FAIL lat0_cycles: got %0d want 1", lat_z); end
    tests_run++;
    if (lat_m != 2) begin tests_failed++; $display("FAIL lat1_cycles: got %0d want 2", lat_m); end
    tests_run++;
    if (lat_t != 4) begin tests_failed++; $display("FAIL lat3_cycles: got %0d want 4", lat_t); end
  endtask

  task automatic test_reset_abort();
    reset_dut();
    set_addr(2, 8'h30);
    req_valid = 4'b0100;
    #1;
    tick();
    req_valid = '0;
    tests_run++;
    if (m_busy !== 1'b1 || m_rom_addr !== 8'h30) begin
      tests_failed++; $display("FAIL abort_pre: got busy=%b addr=%h want 1 30", m_busy, m_rom_addr);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({m_req_ready, m_rsp_valid, m_rsp_id, m_rsp_data, m_rom_addr, m_busy} !== 24'd0) begin
      tests_failed++;
      $display("FAIL abort_async: got ready=%b v=%b id=%0d data=%h addr=%h busy=%b want all 0", m_req_ready, m_rsp_valid, m_rsp_id, m_rsp_data, m_rom_addr, m_busy);
    end
    tests_run++;
    if ({t_rsp_id, t_rom_addr, t_busy} !== 11'd0) begin
      tests_failed++; $display("FAIL abort_async_l3: got id=%0d addr=%h busy=%b want all 0", t_rsp_id, t_rom_addr, t_busy);
    end
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      tests_run++;
      if (m_rsp_valid !== 1'b0 || m_busy !== 1'b0) begin
        tests_failed++; $display("FAIL abort_no_rsp%0d: got v=%b busy=%b want 0 0", c, m_rsp_valid, m_busy);
      end
    end
    req_valid = 4'b1111;
    #1;
    tests_run++;
    if (m_req_ready !== 4'b0001) begin tests_failed++; $display("FAIL abort_ptr: got %b want 0001", m_req_ready); end
    req_valid = 4'b0000;
    tick();
    tests_run++;
    if (m_busy !== 1'b0) begin tests_failed++; $display("FAIL drop_no_grant: got busy=%b want 0", m_busy); end
    req_valid = 4'b1110;
    #1;
    tests_run++;
    if (m_req_ready !== 4'b0010) begin tests_failed++; $display("FAIL drop_ptr_kept: got %b want 0010", m_req_ready); end
    req_valid = '0;
    tick();
  endtask

`ifdef ROM_ARB_RANGE_CHK_EN
  task automatic test_range_chk();
    reset_dut();
    rsp_ready = 1'b1;
    set_addr(0, 8'hD0);
    req_valid = 4'b0001;
    #1;
    tick();
    req_valid = '0;
    for (int c = 0; c < 10; c++) begin
      if (m_rsp_valid) break;
      tick();
    end
    tests_run++;
    if (m_rsp_valid !== 1'b1 || m_rsp_err !== 1'b1 || m_rsp_data !== 8'h00) begin
      tests_failed++; $display("FAIL range_high: got v=%b err=%b data=%h want 1 1 00", m_rsp_valid, m_rsp_err, m_rsp_data);
    end
    tick();
    set_addr(1, 8'h10);
    req_valid = 4'b0010;
    #1;
    tick();
    req_valid = '0;
    for (int c = 0; c < 10; c++) begin
      if (m_rsp_valid) break;
      tick();
    end
    tests_run++;
    if (m_rsp_valid !== 1'b1 || m_rsp_err !== 1'b0 || m_rsp_data !== rom_word(8'h10)) begin
      tests_failed++; $display("FAIL range_low: got v=%b err=%b data=%h want 1 0 %h", m_rsp_valid, m_rsp_err, m_rsp_data, rom_word(8'h10));
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_latency();
    test_reset_abort();
`ifdef ROM_ARB_RANGE_CHK_EN
    test_range_chk();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_rom_rr_arbiter
